// File: rtl/bcd_decoder.sv
// Sequential BCD-to-binary converter: absorbs one packed BCD digit per clock,
// most significant first, using acc*10 + digit.
module bcd_decoder #(
  parameter int DIGITS = 8,
  parameter int OUT_W  = 27
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [3:0]            num_digits,
  output logic [OUT_W-1:0]      binary_out,
  output logic                  done,
  output logic                  busy,
  output logic                  error
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t               state, state_next;
  logic [OUT_W-1:0]     acc;
  logic [OUT_W-1:0]     acc_x10;
  logic [OUT_W-1:0]     acc_step;
  logic [3:0]           cnt;
  logic [4*DIGITS-1:0]  digits;
  logic [4*DIGITS-1:0]  aligned;
  logic [3:0]           top_digit;
  logic                 err_pending;
  logic                 req_bad;
  logic                 accept;
  logic                 step;
  logic                 finish;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (req_bad || num_digits == 4'd0) ? FINISH : RUN;
      RUN:     if (cnt == 4'd1) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept = (state == IDLE) && start;
    step   = (state == RUN);
    finish = (state == FINISH);
  end

  // Only digits below num_digits are checked; anything above is don't-care.
  always_comb begin
    req_bad = (int'(num_digits) > DIGITS);
    for (int k = 0; k < DIGITS; k++) begin
      if ((k < int'(num_digits)) && (bcd_in[4*k +: 4] > 4'd9)) req_bad = 1'b1;
    end
  end

  // Left-align the requested digits so the next digit is always the top nibble.
  always_comb begin
    aligned = '0;
    if (!req_bad) aligned = bcd_in << (4 * (DIGITS - int'(num_digits)));
  end

  always_comb begin
    top_digit = digits[4*DIGITS-1 -: 4];
    acc_x10   = (acc << 3) + (acc << 1);
    acc_step  = acc_x10 + {{(OUT_W-4){1'b0}}, top_digit};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      cnt         <= '0;
      digits      <= '0;
      err_pending <= 1'b0;
      binary_out  <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      error       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        digits      <= aligned;
        cnt         <= num_digits;
        acc         <= '0;
        err_pending <= req_bad;
        busy        <= 1'b1;
      end
      if (step) begin
        acc    <= acc_step;
        cnt    <= cnt - 4'd1;
        digits <= digits << 4;
      end
      if (finish) begin
        done       <= 1'b1;
        busy       <= 1'b0;
        binary_out <= err_pending ? '0 : acc;
        error      <= err_pending;
      end
    end
  end

endmodule

// File: tb/tb_bcd_decoder.sv
// Randomised scoreboard bench for bcd_decoder: a driver pushes expected results
// from an arithmetic model, a negedge monitor pops them on each done pulse.
module tb_bcd_decoder;

  typedef struct {
    logic [31:0] val;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] bcd_in;
  logic [3:0]  num_digits;
  logic [26:0] binary_out;
  logic        done;
  logic        busy;
  logic        error;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] held = '0;
  bit          mon_on = 1'b0;

  bcd_decoder #(.DIGITS(8), .OUT_W(27)) dut (
    .clk(clk), .reset(reset), .start(start), .bcd_in(bcd_in),
    .num_digits(num_digits), .binary_out(binary_out), .done(done),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, actual, actual, expected, expected, cyc);
    end
  endtask

  // Reference: decimal value of the low n digits, rejected if n is too large or a used digit exceeds 9.
  function automatic exp_t model(input logic [31:0] bcd, input int n);
    exp_t e;
    int   pw;
    int   d;
    e.val = 0;
    e.err = (n > 8);
    e.cyc = 0;
    pw = 1;
    if (!e.err) begin
      for (int k = 0; k < n; k++) begin
        d = int'((bcd >> (4 * k)) & 32'hF);
        if (d > 9) e.err = 1'b1;
        e.val = e.val + 32'(d * pw);
        pw = pw * 10;
      end
    end
    if (e.err) e.val = 0;
    return e;
  endfunction

  // Called at a negedge; the following posedge is the start edge.
  task automatic apply_stimulus(input logic [31:0] bcd, input int n, input bit hold);
    exp_t e;
    int   lat;
    e     = model(bcd, n);
    lat   = (e.err || n == 0) ? 1 : n + 1;
    e.cyc = cyc + 1 + lat;
    sb.push_back(e);
    start      = 1'b1;
    bcd_in     = bcd;
    num_digits = 4'(n);
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_done(input int bound, output int busy_cycles);
    int i;
    busy_cycles = 0;
    for (i = 0; i < bound; i++) begin
      if (busy) busy_cycles++;
      if (done) break;
      @(negedge clk);
    end
    if (i == bound) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: no done within %0d cycles, expected a done pulse", bound);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got done=1 result %0d, expected no done", binary_out);
        end else begin
          e = sb.pop_front();
          check_output("result", 32'(binary_out), e.val);
          check_output("error", 32'(error), 32'(e.err));
          check_output("done_cycle", cyc, e.cyc);
          held = e.val;
        end
      end else begin
        check_output("stable_out", 32'(binary_out), held);
      end
    end
  end

  initial begin
    int          bc;
    logic [31:0] bcd;
    int          n;

    reset = 1'b1; start = 1'b0; bcd_in = '0; num_digits = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_output("reset_out", 32'(binary_out), 0);
    check_output("reset_done", 32'(done), 0);
    check_output("reset_busy", 32'(busy), 0);
    check_output("reset_error", 32'(error), 0);
    mon_on = 1'b1;
    @(negedge clk);

    apply_stimulus(32'h12345678, 8, 1'b0);
    wait_done(30, bc);
    check_output("busy_len", bc, 9);
    apply_stimulus(32'h99999999, 8, 1'b0); wait_done(30, bc);
    apply_stimulus(32'h00000000, 8, 1'b0); wait_done(30, bc);
    apply_stimulus(32'hFFFFF042, 3, 1'b0); wait_done(30, bc);
    apply_stimulus(32'h000000A5, 2, 1'b0); wait_done(30, bc);
    apply_stimulus(32'h00000123, 9, 1'b0); wait_done(30, bc);
    apply_stimulus(32'h00000123, 0, 1'b0); wait_done(30, bc);

    // Second start lands while busy and must be dropped.
    apply_stimulus(32'h00000321, 3, 1'b0);
    @(negedge clk);
    start = 1'b1; bcd_in = 32'h00000999; num_digits = 4'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(30, bc);
    repeat (6) @(negedge clk);

    // Abort a conversion mid-RUN.
    apply_stimulus(32'h12345678, 8, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    held = '0;
    @(negedge clk);
    reset = 1'b0;
    check_output("abort_out", 32'(binary_out), 0);
    check_output("abort_done", 32'(done), 0);
    check_output("abort_busy", 32'(busy), 0);
    check_output("abort_error", 32'(error), 0);
    repeat (12) @(negedge clk);

    // start held high: re-accepted on every IDLE edge.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) apply_stimulus(32'h00000007, 1, 1'b1);
      else            apply_stimulus(32'h00000010, 2, 1'b1);
      if (i == 5) begin
        @(negedge clk);
        start = 1'b0;
      end else begin
        repeat ((i % 2 == 0) ? 3 : 4) @(negedge clk);
      end
    end
    wait_done(30, bc);
    @(negedge clk);

    for (int t = 0; t < 60; t++) begin
      n = $urandom_range(0, 9);
      for (int k = 0; k < 8; k++) begin
        bcd[4*k +: 4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15))
                                                      : 4'($urandom_range(0, 9));
      end
      apply_stimulus(bcd, n, 1'b0);
      wait_done(30, bc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check_output("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
